// File: rtl/booth_ctrl_if.sv
// Handshake and strobe bundle between a Booth multiplier datapath and its controller.
// master: the requester/datapath side (drives start, abort, q0, qm1; observes strobes).
// slave : the controller side (booth_ctrl).
// err exists only when BOOTH_CTRL_ERR_EN is defined.
interface booth_ctrl_if;
    logic start;
    logic abort;
    logic q0;
    logic qm1;
    logic ldM;
    logic ldQ;
    logic clrA;
    logic clrff;
    logic ldA;
    logic addsub;
    logic sftA;
    logic sftQ;
    logic sftff;
    logic busy;
    logic done;
`ifdef BOOTH_CTRL_ERR_EN
    logic err;

    modport master (
        output start, abort, q0, qm1,
        input  ldM, ldQ, clrA, clrff, ldA, addsub, sftA, sftQ, sftff, busy, done, err
    );

    modport slave (
        input  start, abort, q0, qm1,
        output ldM, ldQ, clrA, clrff, ldA, addsub, sftA, sftQ, sftff, busy, done, err
    );
`else
    modport master (
        output start, abort, q0, qm1,
        input  ldM, ldQ, clrA, clrff, ldA, addsub, sftA, sftQ, sftff, busy, done
    );

    modport slave (
        input  start, abort, q0, qm1,
        output ldM, ldQ, clrA, clrff, ldA, addsub, sftA, sftQ, sftff, busy, done
    );
`endif
endinterface

// File: rtl/booth_ctrl.sv
// Booth radix-2 multiplier controller: sequences LOAD, then WIDTH rounds of EVAL/SHIFT,
// then a one-cycle DONE pulse.
// Ports:
//   clk    - clock, rising edge
//   clr_n  - asynchronous active-low reset
//   bus    - booth_ctrl_if.slave: start/abort/q0/qm1 in; ldM, ldQ, clrA, clrff, ldA,
//            addsub, sftA, sftQ, sftff, busy, done (and err) out
// Strobes, busy and done are combinational decodes of the state (plus q0/qm1 in EVAL),
// so an asynchronous reset drops them immediately.
// Optional: define BOOTH_CTRL_ERR_EN to add the sticky err output (start seen while busy).
module booth_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    booth_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    // State and iteration counter registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter update and strobe decode
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bus.ldM    = 1'b0;
        bus.ldQ    = 1'b0;
        bus.clrA   = 1'b0;
        bus.clrff  = 1'b0;
        bus.ldA    = 1'b0;
        bus.addsub = 1'b0;
        bus.sftA   = 1'b0;
        bus.sftQ   = 1'b0;
        bus.sftff  = 1'b0;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;

        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                bus.ldM   = 1'b1;
                bus.ldQ   = 1'b1;
                bus.clrA  = 1'b1;
                bus.clrff = 1'b1;
                cnt_nxt   = CNT_W'(WIDTH);
                state_nxt = S_EVAL;
                if (bus.abort) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end

            S_EVAL: begin
                // 10: subtract M, 01: add M, 00/11: no ALU update
                bus.ldA    = bus.q0 ^ bus.qm1;
                bus.addsub = bus.qm1 & ~bus.q0;
                state_nxt  = S_SHIFT;
                if (bus.abort) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end

            S_SHIFT: begin
                bus.sftA  = 1'b1;
                bus.sftQ  = 1'b1;
                bus.sftff = 1'b1;
                // Saturate at zero so the counter can never wrap
                cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : '0;
                state_nxt = (cnt <= CNT_W'(1)) ? S_DONE : S_EVAL;
                if (bus.abort) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end

            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef BOOTH_CTRL_ERR_EN
    logic err_q;

    // Sticky flag for a start request that arrives while a multiply is in flight
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            err_q <= 1'b0;
        end else if (state != S_IDLE && bus.start) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; number of Booth iterations.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: clr_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a multiply; sampled in IDLE only.
REQ-005 Port: abort  input  1  synchronous cancel of a running multiply.
REQ-006 Port: q0  input  1  LSB of multiplier (Q) shift register.
REQ-007 Port: qm1  input  1  Q(-1) flip-flop value.
REQ-008 Port: ldM, ldQ  output  1 each  load multiplicand / multiplier registers.
REQ-009 Port: clrA, clrff  output  1 each  clear accumulator A / Q(-1) flip-flop.
REQ-010 Port: ldA  output  1  load ALU result into A.
REQ-011 Port: addsub  output  1  ALU select; 1 = A+M, 0 = A-M; meaningful only while ldA=1.
REQ-012 Port: sftA, sftQ, sftff  output  1 each  arithmetic right shift of the {A,Q,Q(-1)} chain.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, EVAL, SHIFT and DONE.
REQ-016 IDLE: start=1 -> LOAD; otherwise stay in IDLE; all strobes are 0.
REQ-017 LOAD (1 cycle): ldM=ldQ=clrA=clrff=1; iteration counter cnt<=WIDTH; next state EVAL.
REQ-018 EVAL (1 cycle): {q0,qm1}=10 -> ldA=1, addsub=0; =01 -> ldA=1, addsub=1; =00 or 11 -> ldA=0; next state SHIFT in all cases.
REQ-019 SHIFT (1 cycle): sftA=sftQ=sftff=1, cnt<=cnt-1; cnt==1 -> DONE, else -> EVAL.
REQ-020 DONE (1 cycle): done=1, busy=1; next state IDLE.
REQ-021 cnt width SHALL be $clog2(WIDTH+1); cnt never wraps below 0.
REQ-022 Latency: with start sampled at edge N, done SHALL be high in the cycle following edge N+2*WIDTH+1 (34 cycles for WIDTH=16); a new start is accepted on the edge that leaves DONE.
REQ-023 Strobe outputs SHALL be combinational decodes of state; the EVAL strobes additionally decode q0/qm1; at most one of ld*/sft* groups SHALL be active per cycle.
REQ-024 start outside IDLE SHALL be ignored (no restart, no queueing).
REQ-025 abort=1 in LOAD/EVAL/SHIFT -> IDLE at the next edge, no done pulse, cnt<=0; abort has priority over start; abort in IDLE or DONE has no effect.

Reset
REQ-026 clr_n=0 SHALL immediately force state=IDLE, cnt=0 and every output to 0, including mid-operation.
REQ-027 After clr_n rises, the first start is honoured on the first rising edge.

Configuration
REQ-028 Macro BOOTH_CTRL_ERR_EN defined: extra output err (1 bit), sticky, set when start=1 while busy=1, cleared by reset or on entry to LOAD.
REQ-029 BOOTH_CTRL_ERR_EN undefined: no err port; start while busy is silently ignored; all other behaviour is identical.

Verification
REQ-030 Reset: assert clr_n=0 in SHIFT of iteration 5 -> outputs 0 within the same cycle without a clock edge; busy=0; after release, start -> normal run.
REQ-031 q0=qm1=0 held constant, start pulse -> ldA never asserted, exactly 16 sftA pulses, done high 34 cycles after the start edge.
REQ-032 Closed loop with a 16-bit datapath model: M=7, Q=-3 -> {A,Q}=32'hFFFFFFEB on done; M=-32768, Q=-32768 -> 32'h40000000.
REQ-033 EVAL with {q0,qm1}=10 -> ldA=1, addsub=0 in that cycle; with 01 -> ldA=1, addsub=1; with 11 -> ldA=0.
REQ-034 abort on the 10th cycle after start -> IDLE next cycle, no done pulse; a start 2 cycles later completes with the correct product.
REQ-035 start re-asserted during SHIFT -> run unaffected, done at cycle 34; with BOOTH_CTRL_ERR_EN, err=1 until next LOAD.
